// File: rtl/store_buffer_unit.sv
// Decodes MIPS sb/sh/sw, forms byte-lane enables and replicated data, and queues
// aligned stores in an in-order write buffer drained to memory over valid/ready.
module store_buffer_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [31:0]       Read_data1,
  input  logic [31:0]       Read_data2,
  output logic              stall,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  output logic [31:0]       write_data,
  output logic [3:0]        byte_en,
  input  logic              mem_ready,
  output logic              misaligned_err,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  logic [5:0]        opcode;
  logic [31:0]       imm_sext;
  logic [31:0]       ea_full;
  logic [ADDR_W-1:0] ea;
  logic              is_store;
  logic              aligned;
  logic [3:0]        be_new;
  logic [31:0]       data_new;
  logic              store_req;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic              unused_ok;

  logic [ADDR_W-3:0] ent_addr_q [DEPTH];
  logic [3:0]        ent_be_q   [DEPTH];
  logic [31:0]       ent_data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              err_q;

  assign opcode    = instruction[31:26];
  assign imm_sext  = {{16{instruction[15]}}, instruction[15:0]};
  assign ea_full   = Read_data1 + imm_sext;
  assign ea        = ea_full[ADDR_W-1:0];
  assign unused_ok = ^{instruction[25:16], ea_full};

  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b1;
    be_new   = 4'b0000;
    data_new = 32'h0;
    case (opcode)
      OP_SB: begin
        is_store = 1'b1;
        be_new   = 4'b0001 << ea[1:0];
        data_new = {4{Read_data2[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~ea[0];
        be_new   = ea[1] ? 4'b1100 : 4'b0011;
        data_new = {2{Read_data2[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        aligned  = (ea[1:0] == 2'b00);
        be_new   = 4'b1111;
        data_new = Read_data2;
      end
      default: ;
    endcase
  end

  // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot.
  assign store_req = instr_valid & is_store;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_vld  = (count_q != '0);
  assign push      = store_req & aligned & ~full;
  assign pop       = head_vld & mem_ready;
  assign stall     = reset & store_req & aligned & full;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        ent_addr_q[wr_ptr_q] <= ea[ADDR_W-1:2];
        ent_be_q[wr_ptr_q]   <= be_new;
        ent_data_q[wr_ptr_q] <= data_new;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      err_q   <= store_req & ~aligned;
    end
  end

  // Entry storage is never reset, so head fields are masked while empty.
  assign write_enable   = head_vld;
  assign address        = head_vld ? {ent_addr_q[rd_ptr_q], 2'b00} : '0;
  assign byte_en        = head_vld ? ent_be_q[rd_ptr_q] : 4'b0000;
  assign write_data     = head_vld ? ent_data_q[rd_ptr_q] : 32'h0;
  assign misaligned_err = err_q;
  assign count          = count_q;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Bench for store_buffer_unit: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model.
module tb_store_buffer_unit;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic        stall;
  logic [31:0] address;
  logic        write_enable;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic        mem_ready;
  logic        misaligned_err;
  logic [2:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  logic m_err = 1'b0;

  store_buffer_unit #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .Read_data1(Read_data1), .Read_data2(Read_data2), .stall(stall), .address(address),
    .write_enable(write_enable), .write_data(write_data), .byte_en(byte_en),
    .mem_ready(mem_ready), .misaligned_err(misaligned_err), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] base,
                       input logic [15:0] imm, input logic [31:0] rt, input logic mr);
    instr_valid = v;
    instruction = {op, 5'd1, 5'd2, imm};
    Read_data1  = base;
    Read_data2  = rt;
    mem_ready   = mr;
  endtask

  // Compare outputs against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [5:0]  op;
    logic [31:0] ea;
    logic        st;
    logic        al;
    ent_t        e;
    logic        do_pop;
    logic        do_push;
    @(negedge clk);
    op = instruction[31:26];
    ea = Read_data1 + 32'($signed(instruction[15:0]));
    st = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    al = (op == 6'h29) ? (ea % 2 == 0) : (op == 6'h2B) ? (ea % 4 == 0) : 1'b1;
    chk("we",    write_enable,   mq.size() != 0);
    chk("addr",  address,        mq.size() != 0 ? mq[0].addr : 32'h0);
    chk("be",    byte_en,        mq.size() != 0 ? mq[0].be   : 4'h0);
    chk("data",  write_data,     mq.size() != 0 ? mq[0].data : 32'h0);
    chk("count", count,          mq.size());
    chk("err",   misaligned_err, m_err);
    chk("stall", stall,          reset && instr_valid && st && al && mq.size() == DEPTH);
    if (!reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      do_pop  = (mq.size() != 0) && mem_ready;
      do_push = instr_valid && st && al && mq.size() < DEPTH;
      m_err   = instr_valid && st && !al;
      e.addr  = ea - (ea % 4);
      case (op)
        6'h28:   begin e.be = 4'(1 << (ea % 4)); e.data = Read_data2[7:0] * 32'h01010101; end
        6'h29:   begin e.be = (ea % 4 >= 2) ? 4'hC : 4'h3; e.data = Read_data2[15:0] * 32'h00010001; end
        default: begin e.be = 4'hF; e.data = Read_data2; end
      endcase
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b0);
    #1;
    cycle();
    cycle();
    chk("rst_we", write_enable, 1'b0);
    reset = 1'b1;

    // Single sw drained immediately.
    drive(1'b1, 6'h2B, 32'h0, 16'h0004, 32'h12345678, 1'b1);
    cycle();
    chk("tp1_addr", address, 32'h4);
    chk("tp1_be",   byte_en, 4'hF);
    chk("tp1_data", write_data, 32'h12345678);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1);
    cycle();
    chk("tp1_cnt", count, 3'd0);

    // sw then sb in the top lane.
    drive(1'b1, 6'h2B, 32'h1C, 16'h0020, 32'hABCDEF01, 1'b0);
    cycle();
    chk("tp2_addr", address, 32'h3C);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1);
    cycle();
    drive(1'b1, 6'h28, 32'h1, 16'h0002, 32'hABCDEF01, 1'b0);
    cycle();
    chk("tp2_sb_addr", address, 32'h0);
    chk("tp2_sb_be",   byte_en, 4'b1000);
    chk("tp2_sb_data", write_data, 32'h01010101);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1);
    cycle();

    // sh with negative offset, then a misaligned sh.
    drive(1'b1, 6'h29, 32'h100, 16'hFFFE, 32'h0000BEEF, 1'b0);
    cycle();
    chk("tp3_addr", address, 32'hFC);
    chk("tp3_be",   byte_en, 4'b1100);
    chk("tp3_data", write_data, 32'hBEEFBEEF);
    drive(1'b1, 6'h29, 32'h5, 16'h0000, 32'h1111, 1'b0);
    #1 chk("tp3_mis_nostall", stall, 1'b0);
    cycle();
    chk("tp3_err", misaligned_err, 1'b1);
    chk("tp3_cnt", count, 3'd1);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1);
    cycle();
    chk("tp3_err_clr", misaligned_err, 1'b0);

    // Fill, stall, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 6'h2B, 32'h200 + 32'(i * 4), 16'h0, 32'hA0 + 32'(i), 1'b0);
      cycle();
    end
    chk("tp4_full", count, 3'd4);
    chk("tp4_head", address, 32'h200);
    drive(1'b1, 6'h2B, 32'h300, 16'h0, 32'hDEAD, 1'b0);
    #1 chk("tp4_stall", stall, 1'b1);
    cycle();
    chk("tp4_held", write_data, 32'hA0);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("tp4_order", write_data, 32'hA0 + 32'(i));
      cycle();
      chk("tp4_cnt", count, 3'(DEPTH - 1 - i));
    end

    // Push and pop together at count 2, then a load opcode.
    drive(1'b1, 6'h2B, 32'h400, 16'h0, 32'h1, 1'b0); cycle();
    drive(1'b1, 6'h2B, 32'h404, 16'h0, 32'h2, 1'b0); cycle();
    drive(1'b1, 6'h2B, 32'h408, 16'h0, 32'h3, 1'b1); cycle();
    chk("tp5_cnt",  count, 3'd2);
    chk("tp5_head", address, 32'h404);
    drive(1'b1, 6'h23, 32'h500, 16'h0, 32'h9, 1'b0);
    #1 chk("tp5_ld_stall", stall, 1'b0);
    cycle();
    chk("tp5_ld_err", misaligned_err, 1'b0);
    chk("tp5_ld_cnt", count, 3'd2);

    // Reset discards buffered entries.
    drive(1'b1, 6'h2B, 32'h600, 16'h0, 32'h6, 1'b0); cycle();
    chk("tp6_pre", count, 3'd3);
    reset = 1'b0;
    cycle();
    chk("tp6_we",   write_enable, 1'b0);
    chk("tp6_cnt",  count, 3'd0);
    chk("tp6_addr", address, 32'h0);
    reset = 1'b1;
    drive(1'b1, 6'h2B, 32'h700, 16'h0, 32'h77, 1'b1); cycle();
    chk("tp6_new", address, 32'h700);
    drive(1'b0, 6'h0, 32'h0, 16'h0, 32'h0, 1'b1); cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ops [5];
      ops[0] = 6'h28; ops[1] = 6'h29; ops[2] = 6'h2B; ops[3] = 6'h23;
      ops[4] = 6'($urandom);
      reset = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 4)], $urandom,
            16'($urandom), $urandom, 1'($urandom_range(0, 2) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Parametrised successor to the single-word store stage.
- Decodes MIPS store instructions (sb, sh, sw) and computes the effective address.
- Generates byte-lane enables and replicated write data, then queues each accepted store in a DEPTH-entry in-order write buffer.
- Drains the buffer to data memory over a valid/ready handshake; sits between register-read and the data-memory port.

Parameters:
- ADDR_W, 32, address width; effective address is truncated to the low ADDR_W bits; minimum 3.
- DEPTH, 4, number of write-buffer entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction/operands valid this cycle.
- instruction  in  32  fields: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
- Read_data1  in  32  base register (rs) value.
- Read_data2  in  32  store data register (rt) value.
- stall  out  1  combinational; store presented but buffer full.
- address  out  ADDR_W  word-aligned address of the buffer head.
- write_enable  out  1  head entry valid (request to memory).
- write_data  out  32  lane-replicated data of the head entry.
- byte_en  out  4  byte-lane enables of the head entry.
- mem_ready  in  1  memory accepts the head entry this cycle.
- misaligned_err  out  1  registered one-cycle pulse on a misaligned store.
- count  out  CNT_W  current buffer occupancy.

Behaviour:
- Decode: is_store when opcode is 0x28 (sb), 0x29 (sh) or 0x2B (sw). Any other opcode is ignored: no push, no error, no stall.
- Effective address: EA = Read_data1 + sign-extended imm, taken mod 2^32, then truncated to ADDR_W bits.
- Lane mapping is little-endian:
  - sb: byte_en = 4'b0001 << EA[1:0]; data = {4{rt[7:0]}}.
  - sh: byte_en = EA[1] ? 4'b1100 : 4'b0011; data = {2{rt[15:0]}}.
  - sw: byte_en = 4'b1111; data = rt.
- Alignment: sh requires EA[0]=0; sw requires EA[1:0]=0.
  - A misaligned store is not enqueued.
  - misaligned_err goes to 1 for exactly the cycle after the offending edge.
  - A misaligned store does not assert stall.
- Push: on a rising edge with instr_valid && is_store && aligned && count<DEPTH. Stored fields are {EA[ADDR_W-1:2], byte_en, data}.
- stall = instr_valid && is_store && aligned && count==DEPTH. A pop in the same cycle does not free a slot for that cycle's push.
- Head outputs:
  - write_enable = (count!=0), driven from registered state.
  - address = {head EA[ADDR_W-1:2], 2'b00}.
  - When empty, address, write_data and byte_en are all 0.
- Pop: on an edge with write_enable && mem_ready. While write_enable && !mem_ready, address, write_data and byte_en hold stable.
- Latency: a store pushed into an empty buffer at edge k shows write_enable=1 from edge k until the edge on which it is popped.
- Simultaneous push and pop with 0<count<DEPTH: both happen and count is unchanged. Order is strictly FIFO.
- Pointers wrap modulo DEPTH.
- Reset: reset=0 at a rising edge clears the pointers, count and misaligned_err.
  - All outputs become 0, including write_enable, stall (no store presented), address, write_data and byte_en.
  - Buffered entries are discarded, including during a stalled drain.
  - Inputs are ignored while reset=0.

Test Plan:
- sw, base 0x00000000, imm 0x0004, rt 0x12345678, mem_ready=1 -> next cycle: write_enable=1, address=0x4, byte_en=1111, write_data=0x12345678; after the pop, count=0.
- sw, base 0x0000001C, imm 0x0020, rt 0xABCDEF01 -> address=0x3C, byte_en=1111. Then sb, base 0x1, imm 0x0002, rt 0xABCDEF01 -> address=0x0, byte_en=1000, write_data=0x01010101.
- sh, base 0x00000100, imm 0xFFFE (-2), rt 0x0000BEEF -> EA=0xFE, address=0xFC, byte_en=1100, write_data=0xBEEFBEEF. Then sh with EA=0x5 -> misaligned_err high for one cycle, count unchanged, no write_enable.
- mem_ready=0, four back-to-back sw (DEPTH=4) -> count=4, head held stable. A fifth sw -> stall=1, not enqueued. Then mem_ready=1 -> entries drain one per cycle in issue order and count falls 4,3,2,1,0.
- Push and pop in the same cycle with count=2 -> count stays 2 and order is preserved. A non-store opcode (0x23) with instr_valid=1 -> no push, no stall, no error.
- Three entries buffered with mem_ready=0, then reset=0 for one edge -> write_enable=0, count=0, address=0. After release, a new sw is the first entry drained.
